// File: rtl/memory_arbiter_2port.sv
// Two-master arbiter sharing one single-port synchronous-read RAM.
// Round-robin on ties, lock for atomic sequences, out-of-range accesses filtered.
module memory_arbiter_2port #(
  parameter int DEPTH  = 4096,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_m0_req,
  input  logic              i_m0_lock,
  input  logic              i_m0_wren,
  input  logic [31:0]       i_m0_addr,
  input  logic [3:0]        i_m0_bmask,
  input  logic [31:0]       i_m0_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [31:0]       o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_lock,
  input  logic              i_m1_wren,
  input  logic [31:0]       i_m1_addr,
  input  logic [3:0]        i_m1_bmask,
  input  logic [31:0]       i_m1_wdata,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [31:0]       o_m1_rdata,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [3:0]        o_ram_bmask,
  output logic [31:0]       o_ram_wdata,
  output logic              o_ram_wren,
  input  logic [31:0]       i_ram_rdata
);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        rd0_q, rd0_d;
  logic        rd1_q, rd1_d;
  logic        oor_q, oor_d;

  logic        sel_wren;
  logic [31:0] sel_addr;
  logic [3:0]  sel_bmask;
  logic [31:0] sel_wdata;
  logic        in_range;

  // Grant decision and next state; last_q holds the most recently granted master.
  always_comb begin
    o_m0_gnt = 1'b0;
    o_m1_gnt = 1'b0;
    state_d  = state_q;
    last_d   = last_q;
    case (state_q)
      ARB: begin
        if (i_m0_req && i_m1_req) begin
          if (last_q) o_m0_gnt = 1'b1;
          else        o_m1_gnt = 1'b1;
        end else if (i_m0_req) begin
          o_m0_gnt = 1'b1;
        end else if (i_m1_req) begin
          o_m1_gnt = 1'b1;
        end
      end
      LOCK0: begin
        if (i_m0_req) o_m0_gnt = 1'b1;
        else          state_d  = ARB;
      end
      LOCK1: begin
        if (i_m1_req) o_m1_gnt = 1'b1;
        else          state_d  = ARB;
      end
      default: state_d = ARB;
    endcase
    if (o_m0_gnt) begin
      last_d  = 1'b0;
      state_d = i_m0_lock ? LOCK0 : ARB;
    end else if (o_m1_gnt) begin
      last_d  = 1'b1;
      state_d = i_m1_lock ? LOCK1 : ARB;
    end
  end

  // RAM port mux; everything is forced to zero when nobody is granted.
  always_comb begin
    sel_wren  = o_m1_gnt ? i_m1_wren  : i_m0_wren;
    sel_addr  = o_m1_gnt ? i_m1_addr  : i_m0_addr;
    sel_bmask = o_m1_gnt ? i_m1_bmask : i_m0_bmask;
    sel_wdata = o_m1_gnt ? i_m1_wdata : i_m0_wdata;
    in_range  = (sel_addr[31:ADDR_W] == '0);
    o_ram_addr  = '0;
    o_ram_bmask = '0;
    o_ram_wdata = '0;
    o_ram_wren  = 1'b0;
    if (o_m0_gnt || o_m1_gnt) begin
      o_ram_addr  = sel_addr[ADDR_W-1:0];
      o_ram_bmask = sel_bmask;
      o_ram_wdata = sel_wdata;
      o_ram_wren  = sel_wren & in_range;
    end
    rd0_d = o_m0_gnt & ~i_m0_wren;
    rd1_d = o_m1_gnt & ~i_m1_wren;
    oor_d = ~in_range;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ARB;
      last_q  <= 1'b1;
      rd0_q   <= 1'b0;
      rd1_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      oor_q   <= oor_d;
    end
  end

  // The RAM answers one cycle after the address, so read data is passed through, not registered.
  assign o_m0_rvalid = rd0_q;
  assign o_m1_rvalid = rd1_q;
  assign o_m0_rdata  = (rd0_q && !oor_q) ? i_ram_rdata : 32'h0;
  assign o_m1_rdata  = (rd1_q && !oor_q) ? i_ram_rdata : 32'h0;

endmodule

// File: tb/tb_memory_arbiter_2port.sv
// Directed testbench for memory_arbiter_2port with a small behavioural RAM attached.
module tb_memory_arbiter_2port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_lock, m0_wren, m1_req, m1_lock, m1_wren;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_bmask, m1_bmask;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [11:0] ram_addr;
  logic [3:0]  ram_bmask;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_wren;
  logic [31:0] mem [0:1023];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  memory_arbiter_2port #(.DEPTH(4096)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_m0_req(m0_req), .i_m0_lock(m0_lock), .i_m0_wren(m0_wren), .i_m0_addr(m0_addr),
    .i_m0_bmask(m0_bmask), .i_m0_wdata(m0_wdata),
    .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
    .i_m1_req(m1_req), .i_m1_lock(m1_lock), .i_m1_wren(m1_wren), .i_m1_addr(m1_addr),
    .i_m1_bmask(m1_bmask), .i_m1_wdata(m1_wdata),
    .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
    .o_ram_addr(ram_addr), .o_ram_bmask(ram_bmask), .o_ram_wdata(ram_wdata),
    .o_ram_wren(ram_wren), .i_ram_rdata(ram_rdata)
  );

  // Word-organised RAM model; the bench only issues aligned accesses.
  always @(posedge clk) begin
    if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_bmask[b]) mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr[11:2]];
  end

  task automatic applyStimulus(input int port, input logic req, input logic lock,
                               input logic wren, input logic [31:0] addr,
                               input logic [3:0] bmask, input logic [31:0] wdata);
    if (port == 0) begin
      m0_req = req; m0_lock = lock; m0_wren = wren;
      m0_addr = addr; m0_bmask = bmask; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_lock = lock; m1_wren = wren;
      m1_addr = addr; m1_bmask = bmask; m1_wdata = wdata;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]        = 32'h55AA55AA;
    mem[32'h10/4] = 32'hDEADBEEF;
    mem[32'h20/4] = 32'h01020304;
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 4'h0, 32'h0);
    tick();
    tick();
    checkOutput("reset_m0_rvalid", 32'(m0_rvalid), 32'd0);
    checkOutput("reset_m1_rvalid", 32'(m1_rvalid), 32'd0);
    checkOutput("reset_m0_rdata", m0_rdata, 32'h0);
    rst_n = 1'b1;

    // Single read from m0
    tick();
    applyStimulus(0, 1, 0, 0, 32'h10, 4'h0, 32'h0);
    #1;
    checkOutput("rd_m0_gnt", 32'(m0_gnt), 32'd1);
    checkOutput("rd_m1_gnt", 32'(m1_gnt), 32'd0);
    checkOutput("rd_ram_addr", 32'(ram_addr), 32'h10);
    checkOutput("rd_ram_wren", 32'(ram_wren), 32'd0);
    tick();
    checkOutput("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
    checkOutput("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    checkOutput("rd_m1_rvalid", 32'(m1_rvalid), 32'd0);
    m0_req = 1'b0;
    #1;
    checkOutput("idle_ram_addr", 32'(ram_addr), 32'h0);
    tick();
    checkOutput("rd_m0_rvalid_once", 32'(m0_rvalid), 32'd0);

    // Continuous contention: m0 won last, so m1 goes first and grants alternate
    applyStimulus(0, 1, 0, 0, 32'h10, 4'h0, 32'h0);
    applyStimulus(1, 1, 0, 0, 32'h10, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("rr_m0_gnt_%0d", i), 32'(m0_gnt), 32'(i % 2 == 1));
      checkOutput($sformatf("rr_m1_gnt_%0d", i), 32'(m1_gnt), 32'(i % 2 == 0));
      tick();
      checkOutput($sformatf("rr_m0_rvalid_%0d", i), 32'(m0_rvalid), 32'(i % 2 == 1));
      checkOutput($sformatf("rr_m1_rvalid_%0d", i), 32'(m1_rvalid), 32'(i % 2 == 0));
    end

    // m1 locked read then write while m0 keeps requesting
    applyStimulus(1, 1, 1, 0, 32'h20, 4'h0, 32'h0);
    #1;
    checkOutput("lk_rd_m1_gnt", 32'(m1_gnt), 32'd1);
    checkOutput("lk_rd_m0_gnt", 32'(m0_gnt), 32'd0);
    tick();
    applyStimulus(1, 1, 0, 1, 32'h20, 4'hF, 32'hCAFEF00D);
    #1;
    checkOutput("lk_wr_m1_gnt", 32'(m1_gnt), 32'd1);
    checkOutput("lk_wr_m0_gnt", 32'(m0_gnt), 32'd0);
    checkOutput("lk_m1_rdata", m1_rdata, 32'h01020304);
    tick();
    m1_req = 1'b0;
    #1;
    checkOutput("lk_after_m0_gnt", 32'(m0_gnt), 32'd1);
    checkOutput("lk_wr_no_rvalid", 32'(m1_rvalid), 32'd0);
    tick();
    checkOutput("lk_after_m0_rdata", m0_rdata, 32'hDEADBEEF);

    // Out-of-range write is granted but dropped; read returns zero
    applyStimulus(0, 1, 0, 1, 32'h0000_1000, 4'hF, 32'hFFFFFFFF);
    #1;
    checkOutput("oor_wr_gnt", 32'(m0_gnt), 32'd1);
    checkOutput("oor_wr_wren", 32'(ram_wren), 32'd0);
    checkOutput("oor_wr_addr", 32'(ram_addr), 32'h0);
    tick();
    applyStimulus(0, 1, 0, 0, 32'h0000_1000, 4'h0, 32'h0);
    tick();
    checkOutput("oor_rd_rvalid", 32'(m0_rvalid), 32'd1);
    checkOutput("oor_rd_rdata", m0_rdata, 32'h0);
    checkOutput("oor_mem_untouched", mem[0], 32'h55AA55AA);

    // Write by m0 then immediate read-back by m1
    applyStimulus(0, 1, 0, 1, 32'h8, 4'hF, 32'h11223344);
    #1;
    checkOutput("wr_ram_wren", 32'(ram_wren), 32'd1);
    checkOutput("wr_ram_wdata", ram_wdata, 32'h11223344);
    tick();
    m0_req = 1'b0;
    applyStimulus(1, 1, 0, 0, 32'h8, 4'h0, 32'h0);
    #1;
    checkOutput("rb_m1_gnt", 32'(m1_gnt), 32'd1);
    tick();
    m1_req = 1'b0;
    checkOutput("rb_m1_rvalid", 32'(m1_rvalid), 32'd1);
    checkOutput("rb_m1_rdata", m1_rdata, 32'h11223344);
    checkOutput("rb_m0_rvalid", 32'(m0_rvalid), 32'd0);

    // Reset while entering LOCK0 with a read in flight
    applyStimulus(0, 1, 1, 0, 32'h10, 4'h0, 32'h0);
    #1;
    checkOutput("rst_lk_m0_gnt", 32'(m0_gnt), 32'd1);
    #1;
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
    tick();
    checkOutput("rst_no_rvalid_a", 32'(m0_rvalid), 32'd0);
    tick();
    checkOutput("rst_no_rvalid_b", 32'(m0_rvalid), 32'd0);
    rst_n = 1'b1;
    applyStimulus(0, 1, 0, 0, 32'h10, 4'h0, 32'h0);
    applyStimulus(1, 1, 0, 0, 32'h20, 4'h0, 32'h0);
    #1;
    checkOutput("rst_tie_m0_gnt", 32'(m0_gnt), 32'd1);
    checkOutput("rst_tie_m1_gnt", 32'(m1_gnt), 32'd0);
    m0_req = 1'b0;
    #1;
    checkOutput("rst_arb_m1_gnt", 32'(m1_gnt), 32'd1);
    m1_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
